main_mac_pipe: RTL and testbench

- Parametrised successor to the HLS fixed-latency multiplier cores: an N-stage pipelined multiplier/multiply-accumulate with clock enable, valid tracking, per-operation signed/unsigned mode and an optional accumulate mode.
- Sits in the mloc datapath wherever HLS would otherwise instantiate one fixed main_mul_* core per width and latency.
- Also serves the particle-weight dot-product loops, which need running sums.

---
 rtl/main_mac_pkg.sv | 39 +++
 rtl/main_mac_delay_line.sv | 51 +++++
 rtl/main_mac_pipe.sv | 172 +++++++++++++++++
 tb/tb_main_mac_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_mac_pkg
// Purpose  : Shared types, constants and width helpers for the pipelined
//            multiply / multiply-accumulate block main_mac_pipe.
// Contents : MAC_MAX_STAGE   - deepest supported pipeline (NUM_STAGE upper bound)
//            mac_flags_t     - per-operation control carried down the pipe
//            mac_prod_width  - full-precision product width for two operands
//            mac_delay_depth - number of pure delay stages for a given latency
// Revision : 1.0 - initial release
// ============================================================================
package main_mac_pkg;

    localparam int MAC_MAX_STAGE = 8;

    // Control half of a pipeline stage record. The product half depends on
    // the instance's dout width, so the full record is completed in the top.
    typedef struct packed {
        logic valid;
        logic acc;
    } mac_flags_t;

    // Each operand gains one extension bit so that signed and unsigned
    // operations share a single signed multiplier.
    function automatic int mac_prod_width(input int a_w, input int b_w);
        return a_w + b_w + 2;
    endfunction

    // Stage 1 (operand capture) and the final stage (dout) are real
    // registers; everything in between is a plain delay line. Latencies of
    // 1 and 2 therefore need no delay stages at all.
    function automatic int mac_delay_depth(input int num_stage);
        int n;
        n = (num_stage > MAC_MAX_STAGE) ? MAC_MAX_STAGE : num_stage;
        return (n > 2) ? (n - 2) : 0;
    endfunction

endpackage : main_mac_pkg
`default_nettype wire

// File: rtl/main_mac_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : main_mac_delay_line
// Purpose  : Parametrised register chain with clock enable and synchronous
//            reset. DEPTH=0 degenerates to a combinational pass-through.
// Ports    : clk    - clock, rising edge
//            rst    - synchronous active-high reset, clears every stage
//            i_ce   - clock enable; all stages hold when low
//            i_data - data entering the chain  [WIDTH-1:0]
//            o_data - data leaving the chain   [WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module main_mac_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            // No storage: the control inputs are intentionally unused here.
            logic w_unused_ctl;
            assign w_unused_ctl = &{1'b0, clk, rst, i_ce};
            assign o_data       = i_data;
        end else begin : g_chain
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else if (i_ce) begin
                    r_pipe[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule : main_mac_delay_line
`default_nettype wire

// File: rtl/main_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : main_mac_pipe
// Purpose  : NUM_STAGE-deep pipelined multiplier / multiply-accumulate with
//            clock enable, valid tracking, per-operation signed/unsigned mode
//            and per-operation load/accumulate mode.
// Ports    : clk       - clock, rising edge
//            reset     - synchronous active-high reset (independent of ce)
//            ce        - clock enable; all pipeline state holds when low
//            in_valid  - an operation is present on din0/din1
//            op_signed - 1: two's-complement operands, 0: unsigned
//            op_acc    - 1: dout += product, 0: dout = product
//            din0      - operand A [din0_WIDTH-1:0]
//            din1      - operand B [din1_WIDTH-1:0]
//            out_valid - dout holds the result of a completed operation
//            dout      - result / accumulator register [dout_WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module main_mac_pipe
    import main_mac_pkg::*;
#(
    parameter int din0_WIDTH = 35,
    parameter int din1_WIDTH = 25,
    parameter int dout_WIDTH = 60,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  op_signed,
    input  logic                  op_acc,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int PROD_W    = mac_prod_width(din0_WIDTH, din1_WIDTH);
    localparam int DLY_DEPTH = mac_delay_depth(NUM_STAGE);

    typedef struct packed {
        mac_flags_t              flags;
        logic [dout_WIDTH-1:0]   product;
    } mac_stage_t;

    localparam int STAGE_W = $bits(mac_stage_t);

    // ------------------------------------------------------------------
    // Stage 1: operand capture. With a single-stage pipe the multiplier
    // works straight off the ports and dout is the only register.
    // ------------------------------------------------------------------
    logic [din0_WIDTH-1:0] w_mul_a;
    logic [din1_WIDTH-1:0] w_mul_b;
    logic                  w_mul_sgn;
    logic                  w_mul_acc;
    logic                  w_mul_vld;

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign w_mul_a   = din0;
            assign w_mul_b   = din1;
            assign w_mul_sgn = op_signed;
            assign w_mul_acc = op_acc;
            assign w_mul_vld = in_valid;
        end else begin : g_stage1
            logic [din0_WIDTH-1:0] r_a;
            logic [din1_WIDTH-1:0] r_b;
            logic                  r_sgn;
            logic                  r_acc;
            logic                  r_vld;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sgn <= 1'b0;
                    r_acc <= 1'b0;
                    r_vld <= 1'b0;
                end else if (ce) begin
                    r_a   <= din0;
                    r_b   <= din1;
                    r_sgn <= op_signed;
                    r_acc <= op_acc;
                    r_vld <= in_valid;
                end
            end

            assign w_mul_a   = r_a;
            assign w_mul_b   = r_b;
            assign w_mul_sgn = r_sgn;
            assign w_mul_acc = r_acc;
            assign w_mul_vld = r_vld;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multiplier: one extra bit per operand (sign- or zero-fill by mode)
    // lets a single signed multiply serve both modes exactly.
    // ------------------------------------------------------------------
    logic signed [din0_WIDTH:0] w_a_ext;
    logic signed [din1_WIDTH:0] w_b_ext;
    logic signed [PROD_W-1:0]   w_prod_full;
    logic [dout_WIDTH-1:0]      w_product;

    assign w_a_ext     = {w_mul_sgn & w_mul_a[din0_WIDTH-1], w_mul_a};
    assign w_b_ext     = {w_mul_sgn & w_mul_b[din1_WIDTH-1], w_mul_b};
    assign w_prod_full = PROD_W'(w_a_ext) * PROD_W'(w_b_ext);

    generate
        if (PROD_W > dout_WIDTH) begin : g_trunc
            logic [PROD_W-dout_WIDTH-1:0] w_unused_prod_hi;
            assign w_unused_prod_hi = w_prod_full[PROD_W-1:dout_WIDTH];
            assign w_product        = w_prod_full[dout_WIDTH-1:0];
        end else if (PROD_W == dout_WIDTH) begin : g_exact
            assign w_product = w_prod_full;
        end else begin : g_extend
            assign w_product = {{(dout_WIDTH-PROD_W){w_mul_sgn & w_prod_full[PROD_W-1]}},
                                w_prod_full};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Middle stages: product, valid and acc travel together so that the
    // mode of every operation stays attached to it.
    // ------------------------------------------------------------------
    mac_stage_t w_s1_rec;
    mac_stage_t w_fin_rec;

    always_comb begin
        w_s1_rec             = '0;
        w_s1_rec.flags.valid = w_mul_vld;
        w_s1_rec.flags.acc   = w_mul_acc;
        w_s1_rec.product     = w_product;
    end

    main_mac_delay_line #(
        .DEPTH (DLY_DEPTH),
        .WIDTH (STAGE_W)
    ) u_delay (
        .clk    (clk),
        .rst    (reset),
        .i_ce   (ce),
        .i_data (w_s1_rec),
        .o_data (w_fin_rec)
    );

    // ------------------------------------------------------------------
    // Final stage: dout doubles as the accumulator, so back-to-back
    // accumulate operations chain with no bubble. Sums wrap.
    // ------------------------------------------------------------------
    logic [dout_WIDTH-1:0] r_dout;
    logic                  r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else if (ce) begin
            r_out_valid <= w_fin_rec.flags.valid;
            if (w_fin_rec.flags.valid) begin
                r_dout <= w_fin_rec.flags.acc ? (r_dout + w_fin_rec.product)
                                              : w_fin_rec.product;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_out_valid;

endmodule : main_mac_pipe
`default_nettype wire

// File: tb/tb_main_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mac_pipe
// Purpose  : Directed self-checking bench for main_mac_pipe. A default
//            2-stage instance covers unsigned/signed products, accumulate
//            chains, ce stalls and reset; 1-stage and 5-stage 8x8->12
//            instances cover latency, truncation and randomised operations
//            against a small reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        reset, ce, in_valid, op_signed, op_acc;
    logic [34:0] din0;
    logic [24:0] din1;
    logic        out_valid;
    logic [59:0] dout;

    // sweep instances share one stimulus set
    logic        s_reset, s_ce, s_valid, s_signed, s_acc;
    logic [7:0]  s_a, s_b;
    logic        v1, v5;
    logic [11:0] d1, d5;

    int vectors     = 0;
    int miscompares = 0;

    main_mac_pipe u_dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .op_signed(op_signed), .op_acc(op_acc), .din0(din0), .din1(din1),
        .out_valid(out_valid), .dout(dout)
    );

    main_mac_pipe #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(12), .NUM_STAGE(1)) u_dut1 (
        .clk(clk), .reset(s_reset), .ce(s_ce), .in_valid(s_valid),
        .op_signed(s_signed), .op_acc(s_acc), .din0(s_a), .din1(s_b),
        .out_valid(v1), .dout(d1)
    );

    main_mac_pipe #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(12), .NUM_STAGE(5)) u_dut5 (
        .clk(clk), .reset(s_reset), .ce(s_ce), .in_valid(s_valid),
        .op_signed(s_signed), .op_acc(s_acc), .din0(s_a), .din1(s_b),
        .out_valid(v5), .dout(d5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product for the 8x8->12 instances: exact 64-bit product,
    // low 12 bits kept.
    function automatic logic [11:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic s);
        longint x, y, p;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({56'd0, a});
            y = longint'({56'd0, b});
        end
        p = x * y;
        return p[11:0];
    endfunction

    typedef struct packed {
        logic        v;
        logic        acc;
        logic [11:0] p;
    } op_t;

    logic [11:0] m1_dout = '0, m5_dout = '0;
    logic        m1_v = 1'b0, m5_v = 1'b0;
    op_t         m5_pipe [4];

    // Advance the sweep model with the inputs about to be clocked, take
    // one edge, then compare both sweep instances against the model.
    task automatic sweep_step(input string tag);
        op_t cur, fin;
        cur.v   = s_valid;
        cur.acc = s_acc;
        cur.p   = ref_prod(s_a, s_b, s_signed);
        if (s_reset) begin
            m1_dout = '0; m1_v = 1'b0; m5_dout = '0; m5_v = 1'b0;
            for (int i = 0; i < 4; i++) m5_pipe[i] = '0;
        end else if (s_ce) begin
            m1_v = cur.v;
            if (cur.v) m1_dout = cur.acc ? (m1_dout + cur.p) : cur.p;
            fin  = m5_pipe[3];
            m5_v = fin.v;
            if (fin.v) m5_dout = fin.acc ? (m5_dout + fin.p) : fin.p;
            for (int i = 3; i > 0; i--) m5_pipe[i] = m5_pipe[i-1];
            m5_pipe[0] = cur;
        end
        tick();
        check({tag, "/v1"}, v1, m1_v);
        check({tag, "/d1"}, d1, m1_dout);
        check({tag, "/v5"}, v5, m5_v);
        check({tag, "/d5"}, d5, m5_dout);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m5_pipe[i] = '0;
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; op_signed = 1'b0; op_acc = 1'b0;
        din0 = '0; din1 = '0;
        s_reset = 1'b1; s_ce = 1'b0; s_valid = 1'b0; s_signed = 1'b0; s_acc = 1'b0;
        s_a = '0; s_b = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_vld",  out_valid, 1'b0);
        check("rst_dout", dout, 60'h0);
        check("rst_v1", v1, 1'b0);
        check("rst_d1", d1, 12'h0);
        check("rst_v5", v5, 1'b0);
        check("rst_d5", d5, 12'h0);
        reset = 1'b0; ce = 1'b1;

        // ---------------- unsigned full-width ----------------
        din0 = 35'h7_FFFF_FFFF; din1 = 25'h1FF_FFFF; op_signed = 1'b0; op_acc = 1'b0;
        in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        check("uns_lat1_vld", out_valid, 1'b0);
        tick();
        check("uns_vld",  out_valid, 1'b1);
        check("uns_dout", dout, 60'h0FFF_FFF7_FE00_0001);
        tick();
        check("uns_bubble_vld",  out_valid, 1'b0);
        check("uns_bubble_dout", dout, 60'h0FFF_FFF7_FE00_0001);

        // ---------------- signed then unsigned, back-to-back ----------------
        din0 = 35'h7_FFFF_FFFD; din1 = 25'd5; op_signed = 1'b1; in_valid = 1'b1;
        tick(); op_signed = 1'b0;
        tick(); in_valid = 1'b0;
        check("sgn_vld",  out_valid, 1'b1);
        check("sgn_dout", dout, 60'hFFF_FFFF_FFFF_FFF1);
        tick();
        check("sgn_as_uns_vld",  out_valid, 1'b1);
        check("sgn_as_uns_dout", dout, 60'h27_FFFF_FFF1);

        // ---------------- accumulate chain ----------------
        din0 = 35'd2; din1 = 25'd3; op_acc = 1'b0; in_valid = 1'b1;
        tick();
        check("acc_pre_vld", out_valid, 1'b0);
        din0 = 35'd4; din1 = 25'd5; op_acc = 1'b1;
        tick();
        check("acc0_vld",  out_valid, 1'b1);
        check("acc0_dout", dout, 60'd6);
        din0 = 35'd1; din1 = 25'd7;
        tick(); in_valid = 1'b0; op_acc = 1'b0;
        check("acc1_vld",  out_valid, 1'b1);
        check("acc1_dout", dout, 60'd26);
        tick();
        check("acc2_vld",  out_valid, 1'b1);
        check("acc2_dout", dout, 60'd33);
        tick();
        check("acc_end_vld",  out_valid, 1'b0);
        check("acc_end_dout", dout, 60'd33);

        // ---------------- ce stall ----------------
        din0 = 35'd7; din1 = 25'd9; in_valid = 1'b1;
        tick();
        ce = 1'b0; din0 = 35'd100; din1 = 25'd100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_vld",  out_valid, 1'b0);
            check("stall_dout", dout, 60'd33);
        end
        ce = 1'b1; in_valid = 1'b0;
        tick();
        check("stall_res_vld",  out_valid, 1'b1);
        check("stall_res_dout", dout, 60'd63);
        tick();
        check("stall_after_vld",  out_valid, 1'b0);
        check("stall_after_dout", dout, 60'd63);

        // ---------------- reset mid-flight (ce low) ----------------
        din0 = 35'd11; din1 = 25'd13; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ce = 1'b0; reset = 1'b1;
        tick();
        check("midrst_vld",  out_valid, 1'b0);
        check("midrst_dout", dout, 60'd0);
        reset = 1'b0; ce = 1'b1;
        // accumulate right after reset behaves as a load
        din0 = 35'd6; din1 = 25'd7; op_acc = 1'b1; in_valid = 1'b1;
        tick(); in_valid = 1'b0; op_acc = 1'b0;
        check("postrst_lost_vld",  out_valid, 1'b0);
        check("postrst_lost_dout", dout, 60'd0);
        tick();
        check("postrst_vld",  out_valid, 1'b1);
        check("postrst_dout", dout, 60'd42);

        // ---------------- sweep instances ----------------
        s_reset = 1'b0; s_ce = 1'b1;
        // two ops in flight in the 5-stage pipe, then reset with ce low
        s_a = 8'd3; s_b = 8'd4; s_valid = 1'b1;
        sweep_step("sw_fl0");
        s_a = 8'd5; s_b = 8'd6;
        sweep_step("sw_fl1");
        s_valid = 1'b0; s_ce = 1'b0; s_reset = 1'b1;
        sweep_step("sw_rst");
        s_reset = 1'b0; s_ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sweep_step("sw_norise");
            check("sw_norise_v5", v5, 1'b0);
        end

        // randomised ops including ce stalls and mixed modes
        for (int i = 0; i < 40; i++) begin
            s_ce     = ($urandom_range(0, 3) != 0);
            s_valid  = ($urandom_range(0, 3) != 0);
            s_signed = 1'($urandom_range(0, 1));
            s_acc    = 1'($urandom_range(0, 1));
            s_a      = 8'($urandom_range(0, 255));
            s_b      = 8'($urandom_range(0, 255));
            sweep_step("sw_rand");
        end
        s_ce = 1'b1; s_valid = 1'b0;
        for (int i = 0; i < 5; i++) sweep_step("sw_drain");

        // 255 x 255 unsigned truncates to 12'hE01; latencies 1 and 5
        s_a = 8'd255; s_b = 8'd255; s_signed = 1'b0; s_acc = 1'b0; s_valid = 1'b1;
        sweep_step("sw_e01_e1");
        check("e01_d1", d1, 12'hE01);
        check("e01_v1", v1, 1'b1);
        check("e01_v5_early", v5, 1'b0);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sweep_step("sw_e01_wait");
            check("e01_v5_wait", v5, 1'b0);
        end
        sweep_step("sw_e01_e5");
        check("e01_d5", d5, 12'hE01);
        check("e01_v5", v5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_main_mac_pipe
`default_nettype wire
